mem_lmsm_sequencer: RTL and testbench

- Memory-stage consumer of the EX/MEM pipeline register outputs.
- Expands a single Load-Multiple (LM) or Store-Multiple (SM) instruction into a sequence of single-word memory accesses, one per set bit of the 8-bit register mask.
- Holds the EX/MEM register (and everything upstream) with a stall signal until the last beat has issued.
- Returns LM load data to the register-file write port.

---
 rtl/mem_lmsm_sequencer.sv | 152 +++++++++++++++
 tb/tb_mem_lmsm_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_lmsm_sequencer.sv
// Expands one LM/SM instruction into single-word memory beats, one per set mask bit.
// Latency: beat 0 issues combinationally in the start cycle; N bits -> N beats in N cycles; LM writeback 1 cycle after each beat.
// Backpressure: stall holds EX/MEM and upstream while beats remain after the current one.
module mem_lmsm_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREG   = 8
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    valid,
    input  logic                    lm,
    input  logic                    sm,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [NREG-1:0]         reg_mask,
    output logic [$clog2(NREG)-1:0] rf_raddr,
    input  logic [DATA_W-1:0]       rf_rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic                    mem_re,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    wb_we,
    output logic [$clog2(NREG)-1:0] wb_addr,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    stall,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = $clog2(NREG);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NREG-1:0]     rem_q, rem_d;
    logic [ADDR_W-1:0]   offset_q, offset_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                lm_q, lm_d;
    logic                wbv_q, wbv_d;
    logic [IDX_W-1:0]    wbidx_q, wbidx_d;

    // Beat-selection intermediates
    logic [NREG-1:0]     work_mask;
    logic [NREG-1:0]     rem_next;
    logic [ADDR_W-1:0]   beat_addr;
    logic                beat_lm;
    logic                issue;
    logic [IDX_W-1:0]    idx;

    // State and burst context registers; reset aborts any burst in flight
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            offset_q <= '0;
            base_q   <= '0;
            lm_q     <= 1'b0;
            wbv_q    <= 1'b0;
            wbidx_q  <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            offset_q <= offset_d;
            base_q   <= base_d;
            lm_q     <= lm_d;
            wbv_q    <= wbv_d;
            wbidx_q  <= wbidx_d;
        end
    end

    // Beat selection, memory/RF strobes, stall/done and next-state
    always_comb begin
        work_mask = '0;
        beat_addr = '0;
        beat_lm   = 1'b0;
        issue     = 1'b0;
        idx       = '0;
        state_d   = state_q;
        rem_d     = rem_q;
        offset_d  = offset_q;
        base_d    = base_q;
        lm_d      = lm_q;
        wbv_d     = 1'b0;
        wbidx_d   = wbidx_q;
        rf_raddr  = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = '0;
        stall     = 1'b0;
        done      = 1'b0;

        if (state_q == IDLE) begin
            // LM takes priority when both opcode flags are set
            work_mask = reg_mask;
            beat_addr = base_addr;
            beat_lm   = lm;
            issue     = valid & (lm | sm) & (|reg_mask);
        end else begin
            // EX/MEM is frozen; inputs are not consulted during the burst
            work_mask = rem_q;
            beat_addr = base_q + offset_q;
            beat_lm   = lm_q;
            issue     = |rem_q;
        end
        // Outputs read as zero while reset is asserted, even mid-cycle
        issue = issue & clear;

        // Lowest set bit wins: scan high to low so the last hit is the lowest
        for (int i = NREG - 1; i >= 0; i--) begin
            if (work_mask[i]) idx = IDX_W'(i);
        end
        rem_next = work_mask & (work_mask - NREG'(1));

        if (issue) begin
            mem_addr = beat_addr;
            if (beat_lm) begin
                mem_re  = 1'b1;
                wbv_d   = 1'b1;
                wbidx_d = idx;
            end else begin
                rf_raddr  = idx;
                mem_we    = 1'b1;
                mem_wdata = rf_rdata;
            end
            stall = |rem_next;
            done  = ~(|rem_next);
            rem_d = rem_next;
            if (state_q == IDLE) begin
                base_d   = base_addr;
                lm_d     = lm;
                offset_d = ADDR_W'(1);
            end else begin
                offset_d = offset_q + ADDR_W'(1);
            end
            state_d = (|rem_next) ? BURST : IDLE;
        end else if (state_q == BURST) begin
            state_d = IDLE;
        end
    end

    assign busy    = (state_q == BURST);
    // LM read data passes straight through to the register file one cycle after its beat
    assign wb_we   = wbv_q;
    assign wb_addr = wbv_q ? wbidx_q : '0;
    assign wb_data = wbv_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_lmsm_sequencer.sv
// Directed table-driven bench for mem_lmsm_sequencer with memory and register-file models.
// Latency: each table row is one clock cycle; outputs sampled 2 time units after the falling edge.
// Backpressure: the bench holds EX/MEM inputs steady while stall is high, as the pipeline would.
module tb_mem_lmsm_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        valid, lm, sm;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic [15:0] mem_addr;
    logic        mem_we, mem_re;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall, busy, done;

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] rf  [0:7];

    mem_lmsm_sequencer #(.DATA_W(16), .ADDR_W(16), .NREG(8)) dut (
        .clock     (clock),
        .clear     (clear),
        .valid     (valid),
        .lm        (lm),
        .sm        (sm),
        .base_addr (base_addr),
        .reg_mask  (reg_mask),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .stall     (stall),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    assign rf_rdata = rf[rf_raddr];

    // Synchronous data memory (1-cycle read) and register-file write port
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_re ? mem[mem_addr] : 16'h0000;
        if (wb_we) rf[wb_addr] <= wb_data;
    end

    typedef struct {
        logic        clr, vld, l, s;
        logic [15:0] base;
        logic [7:0]  mask;
        logic        we, re;
        logic [15:0] addr, wd;
        logic        st, dn, bz, wbw;
        logic [2:0]  wba;
        logic [15:0] wbd;
    } vec_t;

    localparam int NV = 20;
    vec_t tv [NV];

    function automatic vec_t mk(input logic c, v, l, s, input logic [15:0] b, input logic [7:0] m,
                                input logic we, re, input logic [15:0] a, wd,
                                input logic st, dn, bz, wbw, input logic [2:0] wa, input logic [15:0] wbd);
        vec_t r;
        r.clr = c; r.vld = v; r.l = l; r.s = s; r.base = b; r.mask = m;
        r.we = we; r.re = re; r.addr = a; r.wd = wd;
        r.st = st; r.dn = dn; r.bz = bz; r.wbw = wbw; r.wba = wa; r.wbd = wbd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        rf[0] = 16'hAAAA; rf[1] = 16'hBBBB; rf[3] = 16'hDDDD;
        mem[16'h0200] = 16'h1234; mem[16'h0201] = 16'h5678;
        mem[16'hFFFF] = 16'h0F0F; mem[16'h0000] = 16'h0A0A;
        clear = 1'b0; valid = 1'b0; lm = 1'b0; sm = 1'b0; base_addr = '0; reg_mask = '0;

        //            clr vld lm sm base      mask  | we re addr      wdata     st dn bz wbw wba wbd
        tv[0]  = mk(0, 1, 0, 1, 16'h0100, 8'h0B,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        tv[1]  = mk(1, 0, 0, 0, 16'h0000, 8'h00,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        tv[2]  = mk(1, 1, 0, 1, 16'h0100, 8'h0B,  1, 0, 16'h0100, 16'hAAAA, 1, 0, 0, 0, 0, 16'h0000);
        tv[3]  = mk(1, 1, 0, 1, 16'h0100, 8'h0B,  1, 0, 16'h0101, 16'hBBBB, 1, 0, 1, 0, 0, 16'h0000);
        tv[4]  = mk(1, 1, 0, 1, 16'h0100, 8'h0B,  1, 0, 16'h0102, 16'hDDDD, 0, 1, 1, 0, 0, 16'h0000);
        tv[5]  = mk(1, 0, 0, 0, 16'h0000, 8'h00,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        tv[6]  = mk(1, 1, 1, 0, 16'h0200, 8'h81,  0, 1, 16'h0200, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
        tv[7]  = mk(1, 1, 1, 0, 16'h0200, 8'h81,  0, 1, 16'h0201, 16'h0000, 0, 1, 1, 1, 0, 16'h1234);
        tv[8]  = mk(1, 0, 0, 0, 16'h0000, 8'h00,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 7, 16'h5678);
        tv[9]  = mk(1, 1, 1, 0, 16'hFFFF, 8'h06,  0, 1, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
        tv[10] = mk(1, 1, 1, 0, 16'hFFFF, 8'h06,  0, 1, 16'h0000, 16'h0000, 0, 1, 1, 1, 1, 16'h0F0F);
        tv[11] = mk(1, 0, 0, 0, 16'h0000, 8'h00,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 2, 16'h0A0A);
        tv[12] = mk(1, 1, 0, 1, 16'h0100, 8'h00,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        tv[13] = mk(1, 0, 1, 1, 16'h0100, 8'hFF,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        tv[14] = mk(1, 1, 1, 0, 16'h0200, 8'h01,  0, 1, 16'h0200, 16'h0000, 0, 1, 0, 0, 0, 16'h0000);
        tv[15] = mk(1, 1, 0, 1, 16'h0300, 8'h02,  1, 0, 16'h0300, 16'h0F0F, 0, 1, 0, 1, 0, 16'h1234);
        tv[16] = mk(1, 0, 0, 0, 16'h0000, 8'h00,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        tv[17] = mk(1, 1, 1, 1, 16'h0201, 8'h01,  0, 1, 16'h0201, 16'h0000, 0, 1, 0, 0, 0, 16'h0000);
        tv[18] = mk(1, 0, 0, 0, 16'h0000, 8'h00,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h5678);
        tv[19] = mk(1, 0, 0, 0, 16'h0000, 8'h00,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            clear = tv[i].clr; valid = tv[i].vld; lm = tv[i].l; sm = tv[i].s;
            base_addr = tv[i].base; reg_mask = tv[i].mask;
            #2;
            chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(tv[i].we));
            chk($sformatf("row%0d mem_re", i), 32'(mem_re), 32'(tv[i].re));
            if (tv[i].we || tv[i].re || !tv[i].clr)
                chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tv[i].addr));
            if (tv[i].we || !tv[i].clr)
                chk($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(tv[i].wd));
            chk($sformatf("row%0d stall", i), 32'(stall), 32'(tv[i].st));
            chk($sformatf("row%0d done", i), 32'(done), 32'(tv[i].dn));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tv[i].bz));
            chk($sformatf("row%0d wb_we", i), 32'(wb_we), 32'(tv[i].wbw));
            if (tv[i].wbw) begin
                chk($sformatf("row%0d wb_addr", i), 32'(wb_addr), 32'(tv[i].wba));
                chk($sformatf("row%0d wb_data", i), 32'(wb_data), 32'(tv[i].wbd));
            end
        end

        // Memory and register file after the table
        chk("mem 0100", 32'(mem[16'h0100]), 32'h0000AAAA);
        chk("mem 0101", 32'(mem[16'h0101]), 32'h0000BBBB);
        chk("mem 0102", 32'(mem[16'h0102]), 32'h0000DDDD);
        chk("mem 0300", 32'(mem[16'h0300]), 32'h00000F0F);
        chk("rf R7",    32'(rf[7]),         32'h00005678);
        chk("rf R2",    32'(rf[2]),         32'h00000A0A);
        chk("rf R0",    32'(rf[0]),         32'h00005678);

        // SM mask 0xFF aborted by reset during beat 3: rf R0..R2 = 5678, 0F0F, 0A0A
        @(negedge clock);
        valid = 1'b1; lm = 1'b0; sm = 1'b1; base_addr = 16'h0400; reg_mask = 8'hFF;
        #2;
        chk("abort b0 addr",  32'(mem_addr), 32'h00000400);
        chk("abort b0 stall", 32'(stall), 32'd1);
        @(negedge clock); #2;
        chk("abort b1 addr",  32'(mem_addr), 32'h00000401);
        @(negedge clock); #2;
        chk("abort b2 addr",  32'(mem_addr), 32'h00000402);
        chk("abort b2 wdata", 32'(mem_wdata), 32'h00000A0A);
        @(negedge clock); #2;
        chk("abort b3 live",  32'(mem_we), 32'd1);
        clear = 1'b0;
        #1;
        chk("abort rst mem_we",    32'(mem_we), 32'd0);
        chk("abort rst mem_re",    32'(mem_re), 32'd0);
        chk("abort rst mem_addr",  32'(mem_addr), 32'd0);
        chk("abort rst mem_wdata", 32'(mem_wdata), 32'd0);
        chk("abort rst stall",     32'(stall), 32'd0);
        chk("abort rst busy",      32'(busy), 32'd0);
        chk("abort rst done",      32'(done), 32'd0);
        chk("abort rst wb_we",     32'(wb_we), 32'd0);
        valid = 1'b0; sm = 1'b0; reg_mask = 8'h00;
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        #2;
        chk("abort rel busy",   32'(busy), 32'd0);
        chk("abort rel stall",  32'(stall), 32'd0);
        chk("abort rel mem_we", 32'(mem_we), 32'd0);
        @(negedge clock); #2;
        chk("abort idle busy",  32'(busy), 32'd0);
        chk("abort mem 0400", 32'(mem[16'h0400]), 32'h00005678);
        chk("abort mem 0401", 32'(mem[16'h0401]), 32'h00000F0F);
        chk("abort mem 0402", 32'(mem[16'h0402]), 32'h00000A0A);
        chk("abort mem 0403", 32'(mem[16'h0403]), 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
